// File: rtl/mem_queue_arbiter_pkg.sv
// Shared constants and types for the mem queue port-A arbiter and its sibling pipeline arbiters.
package mem_queue_arbiter_pkg;

    localparam int READ_NUM_WIDTH = 8;
    localparam int MAX_READ       = 1 << READ_NUM_WIDTH;

    // Mem entry layout: {p_info, p_x2, p_x1, p_x0}, each field in a 64-bit lane.
    localparam int MEM_X_WIDTH    = 33;
    localparam int MEM_X0_LSB     = 0;
    localparam int MEM_X1_LSB     = 64;
    localparam int MEM_X2_LSB     = 128;
    localparam int MEM_INFO_WIDTH = 7;
    localparam int MEM_INFO0_LSB  = 192;
    localparam int MEM_INFO1_LSB  = 224;

    localparam int MAX_REQ        = 8;
    localparam int TAG_IDX_WIDTH  = $clog2(MAX_REQ);

    typedef struct packed {
        logic                     valid;
        logic [TAG_IDX_WIDTH-1:0] idx;
    } mem_tag_t;

endpackage

// File: rtl/mem_queue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, with wrap-around.
module mem_queue_arbiter_rr_arbiter
    import mem_queue_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    int w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = PW'(w_j);
            end
        end
    end

endmodule

// File: rtl/mem_queue_arbiter.sv
// Round-robin arbiter sharing RAM port A between pipeline requesters; returns tagged read data.
// Build option: define MEM_ARB_PRIO0_EN to give requester 0 absolute priority.
module mem_queue_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int READ_NUM_WIDTH = mem_queue_arbiter_pkg::READ_NUM_WIDTH,
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 256
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_stall,
    input  logic [NUM_REQ-1:0]                 i_req,
    input  logic [NUM_REQ-1:0]                 i_req_we,
    input  logic [NUM_REQ*READ_NUM_WIDTH-1:0]  i_req_read_num,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_data,
    output logic [NUM_REQ-1:0]                 o_gnt,
    output logic [NUM_REQ-1:0]                 o_rsp_valid,
    output logic [DATA_WIDTH-1:0]              o_rsp_data,
    output logic [READ_NUM_WIDTH-1:0]          o_mem_read_num_1,
    output logic                               o_mem_we_1,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr_1,
    output logic [DATA_WIDTH-1:0]              o_mem_data_1,
    input  logic [DATA_WIDTH-1:0]              i_mem_q_1,
    output logic                               o_busy
);
    import mem_queue_arbiter_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_rr_req;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [IW-1:0]      w_rr_idx;
    logic               w_rr_any;
    logic               w_prio_win;
    logic [NUM_REQ-1:0] w_win_gnt;
    logic [IW-1:0]      w_win_idx;
    logic               w_win_any;

    logic [IW-1:0]      r_rr_ptr;
    mem_tag_t           r_tag1;
    mem_tag_t           r_tag2;

`ifdef MEM_ARB_PRIO0_EN
    // Requester 0 bypasses the ring; the others keep rotating among themselves.
    assign w_rr_req   = i_req & ~NUM_REQ'(1);
    assign w_prio_win = i_req[0];
`else
    assign w_rr_req   = i_req;
    assign w_prio_win = 1'b0;
`endif

    mem_queue_arbiter_rr_arbiter #(
        .N  (NUM_REQ),
        .PW (IW)
    ) u_rr (
        .i_req (w_rr_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    always_comb begin
        w_win_gnt = w_rr_gnt;
        w_win_idx = w_rr_idx;
        w_win_any = w_rr_any;
        if (w_prio_win) begin
            w_win_gnt = NUM_REQ'(1);
            w_win_idx = '0;
            w_win_any = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_gnt            <= '0;
            o_rsp_valid      <= '0;
            o_rsp_data       <= '0;
            o_mem_read_num_1 <= '0;
            o_mem_we_1       <= 1'b0;
            o_mem_addr_1     <= '0;
            o_mem_data_1     <= '0;
            r_rr_ptr         <= '0;
            r_tag1           <= '0;
            r_tag2           <= '0;
        end else begin
            o_gnt      <= '0;
            o_mem_we_1 <= 1'b0;
            r_tag1     <= '0;
            // Address/read-number hold while idle so the RAM just repeats a harmless read.
            if (!i_stall && w_win_any) begin
                o_gnt            <= w_win_gnt;
                o_mem_we_1       <= i_req_we[w_win_idx];
                o_mem_read_num_1 <= i_req_read_num[w_win_idx*READ_NUM_WIDTH +: READ_NUM_WIDTH];
                o_mem_addr_1     <= i_req_addr[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                o_mem_data_1     <= i_req_data[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
                r_tag1.valid     <= ~i_req_we[w_win_idx];
                r_tag1.idx       <= TAG_IDX_WIDTH'(w_win_idx);
                if (!w_prio_win) begin
                    r_rr_ptr <= (w_win_idx == IW'(NUM_REQ-1)) ? '0 : w_win_idx + 1'b1;
                end
            end
            // Tag pipeline keeps moving under stall so in-flight reads always complete.
            r_tag2      <= r_tag1;
            o_rsp_valid <= '0;
            if (r_tag2.valid) begin
                o_rsp_valid <= NUM_REQ'(1) << r_tag2.idx;
                o_rsp_data  <= i_mem_q_1;
            end
        end
    end

    assign o_busy = r_tag1.valid | r_tag2.valid;

endmodule

// File: tb/tb_mem_queue_arbiter.sv
// Bench for mem_queue_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_queue_arbiter;
    localparam int N  = 4;
    localparam int RW = 8;
    localparam int AW = 7;
    localparam int DW = 256;
`ifdef MEM_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, stall;
    logic [N-1:0]  req, req_we;
    logic [N*RW-1:0] req_read_num;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt, rsp_valid;
    logic [DW-1:0] rsp_data, mem_data, mem_q;
    logic [RW-1:0] mem_read_num;
    logic [AW-1:0] mem_addr;
    logic          mem_we, busy;

    mem_queue_arbiter #(.NUM_REQ(N), .READ_NUM_WIDTH(RW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_req(req), .i_req_we(req_we),
        .i_req_read_num(req_read_num), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_mem_read_num_1(mem_read_num), .o_mem_we_1(mem_we), .o_mem_addr_1(mem_addr),
        .o_mem_data_1(mem_data), .i_mem_q_1(mem_q), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // RAM port A: registered read, read-before-write.
    logic [DW-1:0] ram [0:127];
    always @(posedge clk) begin
        mem_q <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_data;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int            m_ptr = 0;
    logic [DW-1:0] m_mem [0:127];
    bit            m_known [0:127];
    typedef struct {int due; int idx; logic [DW-1:0] data; bit known;} rsp_t;
    rsp_t          m_rsp [$];

    logic          r_we   [N];
    logic [RW-1:0] r_rn   [N];
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_data [N];

    function automatic logic [DW-1:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input int i, input logic we, input logic [RW-1:0] rn,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        r_we[i] = we; r_rn[i] = rn; r_addr[i] = a; r_data[i] = d;
        req_we[i] = we;
        req_read_num[i*RW +: RW] = rn;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Winner: requester 0 if prioritised, else first requester found walking the ring from the pointer.
    function automatic int model_pick(input logic [N-1:0] r);
        int j;
        if (PRIO && r[0]) return 0;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!(PRIO && j == 0) && r[j]) begin
                m_ptr = (j + 1) % N;
                return j;
            end
        end
        return -1;
    endfunction

    task automatic model_issue(output int w);
        rsp_t e;
        w = -1;
        if (!stall) w = model_pick(req);
        if (w >= 0) begin
            if (r_we[w]) begin
                m_mem[r_addr[w]] = r_data[w];
                m_known[r_addr[w]] = 1'b1;
            end else begin
                e.due = cyc + 3; e.idx = w;
                e.data = m_mem[r_addr[w]]; e.known = m_known[r_addr[w]];
                m_rsp.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; req = '0;
        tick(); tick();
        m_ptr = 0; m_rsp.delete();
        n_cmp++; if ({gnt, rsp_valid, mem_we, busy} !== '0) begin n_err++; $display("FAIL rst_ctl got=%b exp=0", {gnt, rsp_valid, mem_we, busy}); end
        n_cmp++; if ({mem_read_num, mem_addr} !== '0) begin n_err++; $display("FAIL rst_mem got=%h exp=0", {mem_read_num, mem_addr}); end
        n_cmp++; if ({rsp_data, mem_data} !== '0) begin n_err++; $display("FAIL rst_data got=%h exp=0", {rsp_data, mem_data}); end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        test_reset();
        load(2, 1'b1, 8'd5, 7'd3, DW'(12'hABC)); req = 4'b0100; tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL sr_wgnt got=%b exp=0100", gnt); end
        n_cmp++; if ({mem_we, mem_read_num, mem_addr} !== {1'b1, 8'd5, 7'd3}) begin n_err++; $display("FAIL sr_wport got=%h exp=%h", {mem_we, mem_read_num, mem_addr}, {1'b1, 8'd5, 7'd3}); end
        n_cmp++; if (mem_data !== DW'(12'hABC)) begin n_err++; $display("FAIL sr_wdata got=%h exp=abc", mem_data); end
        req = '0; tick();
        load(2, 1'b0, 8'd5, 7'd3, '0); req = 4'b0100; tick();
        n_cmp++; if ({gnt, mem_we, busy} !== {4'b0100, 1'b0, 1'b1}) begin n_err++; $display("FAIL sr_rgnt got=%b exp=0100_0_1", {gnt, mem_we, busy}); end
        req = '0; tick();
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL sr_early got=%b exp=0000", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL sr_valid got=%b exp=0100", rsp_valid); end
        n_cmp++; if (rsp_data !== DW'(12'hABC)) begin n_err++; $display("FAIL sr_data got=%h exp=abc", rsp_data); end
        tick();
        n_cmp++; if ({rsp_valid, busy} !== 5'b0) begin n_err++; $display("FAIL sr_after got=%b exp=0", {rsp_valid, busy}); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] wd [N];
        int e;
        test_reset();
        for (int i = 0; i < N; i++) begin wd[i] = rnd256(); load(i, 1'b1, RW'(i), AW'(10 + i), wd[i]); end
        req = '1;
        for (int k = 0; k < N; k++) begin
            tick();
            e = PRIO ? 0 : k;
            n_cmp++; if ({gnt, mem_addr} !== {N'(1) << e, AW'(10 + e)}) begin n_err++; $display("FAIL rr_wr%0d got=%h exp=%h", k, {gnt, mem_addr}, {N'(1) << e, AW'(10 + e)}); end
        end
        for (int i = 0; i < N; i++) load(i, 1'b0, RW'(i), AW'(10 + i), '0);
        for (int k = 0; k < 12; k++) begin
            tick();
            e = PRIO ? 0 : k % N;
            n_cmp++; if (gnt !== N'(1) << e) begin n_err++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, N'(1) << e); end
            if (k < 2) begin
                n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rr_rsp%0d got=%b exp=0000", k, rsp_valid); end
            end else begin
                e = PRIO ? 0 : (k - 2) % N;
                n_cmp++; if (rsp_valid !== N'(1) << e) begin n_err++; $display("FAIL rr_rsp%0d got=%b exp=%b", k, rsp_valid, N'(1) << e); end
                n_cmp++; if (rsp_data !== wd[e]) begin n_err++; $display("FAIL rr_data%0d got=%h exp=%h", k, rsp_data, wd[e]); end
            end
        end
        req = '0; tick(); tick(); tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d1, d2;
        d1 = rnd256(); d2 = rnd256();
        load(1, 1'b1, 8'd7, 7'd100, d1); req = 4'b0010; tick();
        n_cmp++; if ({gnt, mem_we, mem_read_num, mem_addr} !== {4'b0010, 1'b1, 8'd7, 7'd100}) begin n_err++; $display("FAIL wr_w1 got=%h exp=%h", {gnt, mem_we, mem_read_num, mem_addr}, {4'b0010, 1'b1, 8'd7, 7'd100}); end
        load(1, 1'b0, 8'd7, 7'd100, '0); tick();
        n_cmp++; if ({gnt, mem_we} !== 5'b0010_0) begin n_err++; $display("FAIL wr_r1 got=%b exp=00100", {gnt, mem_we}); end
        load(1, 1'b1, 8'd7, 7'd100, d2); tick();
        n_cmp++; if ({gnt, mem_we} !== 5'b0010_1) begin n_err++; $display("FAIL wr_w2 got=%b exp=00101", {gnt, mem_we}); end
        req = '0; tick();
        n_cmp++; if ({rsp_valid, rsp_data} !== {4'b0010, d1}) begin n_err++; $display("FAIL wr_old got=%b/%h exp=0010/%h", rsp_valid, rsp_data, d1); end
        load(1, 1'b0, 8'd7, 7'd100, '0); req = 4'b0010; tick();
        req = '0; tick(); tick();
        n_cmp++; if ({rsp_valid, rsp_data} !== {4'b0010, d2}) begin n_err++; $display("FAIL wr_new got=%b/%h exp=0010/%h", rsp_valid, rsp_data, d2); end
    endtask

    task automatic test_stall();
        test_reset();
        load(1, 1'b0, 8'd3, 7'd10, '0); req = 4'b0010; tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL st_pre got=%b exp=0010", gnt); end
        for (int i = 0; i < N; i++) load(i, 1'b0, RW'(i), AW'(20 + i), '0);
        req = 4'b1110; stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if ({gnt, mem_we, mem_addr} !== {4'b0000, 1'b0, 7'd10}) begin n_err++; $display("FAIL st_hold%0d got=%h exp=%h", k, {gnt, mem_we, mem_addr}, {4'b0000, 1'b0, 7'd10}); end
            n_cmp++; if (rsp_valid !== ((k == 1) ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL st_rsp%0d got=%b", k, rsp_valid); end
        end
        stall = 1'b0; tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL st_res0 got=%b exp=0100", gnt); end
        tick();
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL st_res1 got=%b exp=1000", gnt); end
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL st_res2 got=%b exp=0010", gnt); end
        req = '0; tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        test_reset();
        load(2, 1'b0, 8'd1, 7'd10, '0); req = 4'b0100; tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL rm_gnt got=%b exp=0100", gnt); end
        req = '0; reset = 1'b1; tick();
        n_cmp++; if ({gnt, rsp_valid, mem_we, busy, mem_addr, mem_read_num} !== '0) begin n_err++; $display("FAIL rm_zero got=%h exp=0", {gnt, rsp_valid, mem_we, busy, mem_addr, mem_read_num}); end
        reset = 1'b0; tick();
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rm_rsp0 got=%b exp=0000", rsp_valid); end
        load(1, 1'b0, 8'd0, 7'd11, '0); load(3, 1'b0, 8'd0, 7'd13, '0); req = 4'b1010; tick();
        n_cmp++; if ({rsp_valid, gnt} !== 8'b0000_0010) begin n_err++; $display("FAIL rm_ptr got=%b exp=00000010", {rsp_valid, gnt}); end
        req = '0; tick(); tick(); tick();
    endtask

    task automatic test_prio();
        logic [N-1:0] e;
        test_reset();
        load(0, 1'b0, 8'd0, 7'd10, '0); load(3, 1'b0, 8'd3, 7'd13, '0); req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            e = (PRIO || k % 2 == 0) ? 4'b0001 : 4'b1000;
            n_cmp++; if (gnt !== e) begin n_err++; $display("FAIL pr_gnt%0d got=%b exp=%b", k, gnt, e); end
        end
        req = 4'b1000; tick();
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL pr_last got=%b exp=1000", gnt); end
        req = '0; tick(); tick(); tick();
    endtask

    task automatic test_random();
        bit pend [N];
        int w;
        logic [N-1:0] ev;
        rsp_t h;
        test_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    load(i, 1'($urandom_range(0, 1)), RW'($urandom), AW'(32 + $urandom_range(0, 7)), rnd256());
                end
                req[i] = pend[i];
            end
            stall = ($urandom_range(0, 4) == 0);
            model_issue(w);
            tick();
            n_cmp++; if (gnt !== ((w >= 0) ? N'(1) << w : N'(0))) begin n_err++; $display("FAIL rnd_gnt c%0d got=%b exp_idx=%0d", c, gnt, w); end
            n_cmp++; if (mem_we !== ((w >= 0) ? r_we[w] : 1'b0)) begin n_err++; $display("FAIL rnd_we c%0d got=%b", c, mem_we); end
            if (w >= 0) begin
                n_cmp++; if ({mem_read_num, mem_addr} !== {r_rn[w], r_addr[w]}) begin n_err++; $display("FAIL rnd_port c%0d got=%h exp=%h", c, {mem_read_num, mem_addr}, {r_rn[w], r_addr[w]}); end
                if (r_we[w]) begin
                    n_cmp++; if (mem_data !== r_data[w]) begin n_err++; $display("FAIL rnd_wdata c%0d got=%h exp=%h", c, mem_data, r_data[w]); end
                end
                pend[w] = 1'b0;
            end
            ev = '0;
            if (m_rsp.size() != 0 && m_rsp[0].due == cyc) begin
                h = m_rsp.pop_front();
                ev = N'(1) << h.idx;
                if (h.known) begin
                    n_cmp++; if (rsp_data !== h.data) begin n_err++; $display("FAIL rnd_rdata c%0d got=%h exp=%h", c, rsp_data, h.data); end
                end
            end
            n_cmp++; if (rsp_valid !== ev) begin n_err++; $display("FAIL rnd_rsp c%0d got=%b exp=%b", c, rsp_valid, ev); end
            n_cmp++; if (busy !== (m_rsp.size() != 0)) begin n_err++; $display("FAIL rnd_busy c%0d got=%b exp=%b", c, busy, m_rsp.size() != 0); end
        end
        stall = 1'b0; req = '0; tick(); tick(); tick();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req = '0; req_we = '0;
        req_read_num = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < N; i++) begin r_we[i] = 1'b0; r_rn[i] = '0; r_addr[i] = '0; r_data[i] = '0; end
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_stall();
        test_reset_mid();
        test_prio();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
